// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX stage and the iterative mul/div unit.
// master: pipeline side (drives operands, consumes result); slave: the unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, op, srcA, srcB, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, srcA, srcB, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M mul/div: radix-2 shift-add multiply, restoring divide.
// Ports: clk, reset (async high), flush, bus (slave handshake), busy.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit FAST_SPC = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    muldiv_unit_if.slave   bus,
    output logic           busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZX = '0;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] m_q, hi_q, lo_q, res_q;
    logic            ov_q;

    logic            accept, is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic            b_zero, ovf, special, neg_in;
    logic [XLEN-1:0] a_mag, b_mag, spc_res;
    logic [XLEN:0]   mul_s, div_sh, div_d;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_res;

    assign bus.in_ready  = (state == IDLE) && !flush;
    assign bus.out_valid = ov_q;
    assign bus.result    = res_q;
    assign bus.zero      = (res_q == ZX);
    assign busy          = (state != IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    // Operand decode: magnitudes feed the unsigned datapath, sign fixed later.
    always_comb begin
        is_div  = bus.op[2];
        sgn_a   = is_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
        sgn_b   = is_div ? ~bus.op[0] : ~bus.op[1];
        a_neg   = sgn_a & bus.srcA[XLEN-1];
        b_neg   = sgn_b & bus.srcB[XLEN-1];
        a_mag   = a_neg ? ZX - bus.srcA : bus.srcA;
        b_mag   = b_neg ? ZX - bus.srcB : bus.srcB;
        b_zero  = (bus.srcB == ZX);
        ovf     = is_div & ~bus.op[0] & (bus.srcA == MIN_INT) & (&bus.srcB);
        special = FAST_SPC && is_div && (b_zero || ovf);
        if (b_zero)
            spc_res = bus.op[1] ? bus.srcA : '1;
        else
            spc_res = bus.op[1] ? ZX : bus.srcA;
        // Remainder follows the dividend; a zero divisor keeps the
        // all-ones quotient the iteration produces, so never negate it.
        if (is_div && bus.op[1])
            neg_in = a_neg;
        else
            neg_in = (a_neg ^ b_neg) & ~(is_div & b_zero);
    end

    // One iteration step for each datapath, and the final sign fix.
    always_comb begin
        mul_s  = {1'b0, hi_q} + ({1'b0, m_q} & {(XLEN+1){lo_q[0]}});
        div_sh = {hi_q, lo_q[XLEN-1]};
        div_d  = div_sh - {1'b0, m_q};
        prod_s = neg_q ? {ZX, ZX} - {hi_q, lo_q} : {hi_q, lo_q};
        quo_s  = neg_q ? ZX - lo_q : lo_q;
        rem_s  = neg_q ? ZX - hi_q : hi_q;
        if (op_q[2])
            fix_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00)
            fix_res = prod_s[XLEN-1:0];
        else
            fix_res = prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nxt = special ? DONE : BUSY;
                BUSY: if (cnt == CW'(XLEN-1)) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: if (ov_q && bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            res_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            // out_valid is registered one cycle behind entry to DONE.
            if (flush || state != DONE)
                ov_q <= 1'b0;
            else if (!ov_q)
                ov_q <= 1'b1;
            else if (bus.out_ready)
                ov_q <= 1'b0;

            if (accept) begin
                op_q  <= bus.op;
                neg_q <= neg_in;
                cnt   <= '0;
                hi_q  <= '0;
                lo_q  <= is_div ? a_mag : b_mag;
                m_q   <= is_div ? b_mag : a_mag;
                if (special) res_q <= spc_res;
            end else if (!flush && state == BUSY) begin
                if (cnt != CW'(XLEN-1)) cnt <= cnt + 1'b1;
                if (op_q[2]) begin
                    if (!div_d[XLEN]) begin
                        hi_q <= div_d[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_q <= div_sh[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_q <= mul_s[XLEN:1];
                    lo_q <= {mul_s[0], lo_q[XLEN-1:1]};
                end
            end else if (!flush && state == FIX) begin
                res_q <= fix_res;
            end
        end
    end
endmodule
